// File: rtl/wb_gpio_pkg.sv
// Shared register indices and byte-enable helpers for the Wishbone GPIO block.
package wb_gpio_pkg;

  localparam logic [2:0] REG_IN      = 3'd0;
  localparam logic [2:0] REG_OUT     = 3'd1;
  localparam logic [2:0] REG_DIR     = 3'd2;
  localparam logic [2:0] REG_SET     = 3'd3;
  localparam logic [2:0] REG_CLR     = 3'd4;
  localparam logic [2:0] REG_RISE_EN = 3'd5;
  localparam logic [2:0] REG_FALL_EN = 3'd6;
  localparam logic [2:0] REG_STATUS  = 3'd7;

  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Multi-flop input synchroniser with a previous-value register
// producing per-bit rise/fall strobes.
module gpio_sync_edge #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  logic [STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]             r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO controller: direction, atomic set/clear,
// synchronised inputs and sticky edge status with a level interrupt.
module wb_gpio_irq
  import wb_gpio_pkg::*;
#(
  parameter int                    GPIO_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [GPIO_WIDTH-1:0] OUT_RESET   = '0,
  parameter logic [GPIO_WIDTH-1:0] DIR_RESET   = '0
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [4:0]            wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_dir_o,
  output logic                  irq_o
);

  localparam int W = GPIO_WIDTH;

  logic [W-1:0] r_out;
  logic [W-1:0] r_dir;
  logic [W-1:0] r_rise_en;
  logic [W-1:0] r_fall_en;
  logic [W-1:0] r_status;
  logic [31:0]  r_dat;
  logic         r_ack;
  logic         r_irq;

  logic [W-1:0] w_sync;
  logic [W-1:0] w_rise;
  logic [W-1:0] w_fall;
  logic         w_acc;
  logic         w_wr;
  logic [2:0]   w_idx;
  logic [31:0]  w_mask32;
  logic [W-1:0] w_mask;
  logic [W-1:0] w_wd;
  logic [W-1:0] w_clr;
  logic [W-1:0] w_status_nxt;
  logic [W-1:0] w_rd;
  logic         w_unused;

  gpio_sync_edge #(
    .WIDTH  (W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk  (wb_clk_i),
    .i_rst  (wb_rst_i),
    .i_d    (gpio_i),
    .o_sync (w_sync),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_acc    = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr     = w_acc & wb_we_i;
  assign w_idx    = wb_adr_i[4:2];
  assign w_mask32 = sel_mask(wb_sel_i);
  assign w_mask   = w_mask32[W-1:0];
  assign w_wd     = wb_dat_i[W-1:0] & w_mask;
  assign w_unused = ^{wb_adr_i[1:0], wb_dat_i, w_mask32};

  // A fresh edge overrides a simultaneous W1C clear.
  assign w_clr = (w_wr && w_idx == REG_STATUS) ? w_wd : '0;
  assign w_status_nxt = (r_status & ~w_clr)
                      | (w_rise & r_rise_en)
                      | (w_fall & r_fall_en);

  always_comb begin
    w_rd = '0;
    case (w_idx)
      REG_IN:      w_rd = w_sync;
      REG_OUT:     w_rd = r_out;
      REG_DIR:     w_rd = r_dir;
      REG_RISE_EN: w_rd = r_rise_en;
      REG_FALL_EN: w_rd = r_fall_en;
      REG_STATUS:  w_rd = r_status;
      default:     w_rd = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_out     <= OUT_RESET;
      r_dir     <= DIR_RESET;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_status  <= '0;
      r_dat     <= '0;
      r_ack     <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_ack    <= w_acc;
      r_irq    <= |r_status;
      r_status <= w_status_nxt;
      if (w_acc) r_dat <= 32'(w_rd);
      if (w_wr) begin
        case (w_idx)
          REG_OUT:     r_out     <= (r_out & ~w_mask) | w_wd;
          REG_DIR:     r_dir     <= (r_dir & ~w_mask) | w_wd;
          REG_SET:     r_out     <= r_out | w_wd;
          REG_CLR:     r_out     <= r_out & ~w_wd;
          REG_RISE_EN: r_rise_en <= (r_rise_en & ~w_mask) | w_wd;
          REG_FALL_EN: r_fall_en <= (r_fall_en & ~w_mask) | w_wd;
          default: ;
        endcase
      end
    end
  end

  assign wb_dat_o   = r_dat;
  assign wb_ack_o   = r_ack;
  assign gpio_o     = r_out;
  assign gpio_dir_o = r_dir;
  assign irq_o      = r_irq;

endmodule
